switch_port_rx: RTL and testbench
=================================

Name: switch_port_rx

Overview:
- Synthesizable egress receiver attached to one output side of switch_4port (valid_out/source/target/data_out of one port_if).
- Validates each delivered packet {target(4, one-hot), source(4, one-hot), data(8)} against its own port ID.
- Buffers valid packets in a show-ahead FIFO for a downstream consumer.
- Keeps per-source delivery counters and sticky error flags; serves as the system-level counterpart to the ingress driver.

Parameters:
- PORT_ID, 4'b0010, one-hot ID of the switch port this receiver serves.
- DEPTH, 4, FIFO entries; power of 2, minimum 2.
- CNT_W, 16, width of each statistics counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pkt_valid  in  1  packet strobe from the switch egress (valid_out); one packet per high cycle.
- pkt_source  in  4  one-hot source port of the packet.
- pkt_target  in  4  one-hot target port of the packet.
- pkt_data  in  8  payload.
- rd_en  in  1  consumer pop request.
- rd_valid  out  1  FIFO non-empty; head entry is presented.
- rd_source  out  4  source field of the head entry.
- rd_data  out  8  payload of the head entry.
- fifo_count  out  $clog2(DEPTH)+1  current occupancy.
- src_cnt  out  4*CNT_W  per-source accepted-packet counters; slice i counts source bit i.
- drop_cnt  out  CNT_W  packets lost to a full FIFO.
- misroute_err  out  1  sticky: a packet arrived with pkt_target != PORT_ID.
- bad_src_err  out  1  sticky: a packet arrived with a non-one-hot source, or with source == PORT_ID.
- overflow  out  1  sticky: at least one drop has occurred.
- clr_stats  in  1  synchronous clear of all counters and sticky flags.

Behaviour:
- Reset (async, rst_n=0):
  - FIFO empties; rd_valid=0, rd_source=0, rd_data=0, fifo_count=0.
  - All counters cleared; all sticky flags cleared.
  - Reset asserted mid-traffic discards all buffered entries immediately.
- Classification happens in the pkt_valid cycle, combinationally on the inputs. Error priority is misroute, then bad source, then full.
  - Misroute: packet is not stored, no counter increments, misroute_err is set.
  - Bad source: packet is not stored, bad_src_err is set.
  - Good packet with FIFO not full, or full with pop in the same cycle: write to FIFO and increment src_cnt[bit index of source].
  - Good packet with FIFO full and no pop: discard, increment drop_cnt, set overflow.
- Latency: a packet accepted at edge N gives rd_valid=1 and head data on rd_* after edge N.
  - If the FIFO was empty, the packet is visible one cycle after its pkt_valid cycle.
- Pop: rd_en && rd_valid advances the head at the clock edge. rd_en while empty is ignored; there is no underflow error.
- Simultaneous push and pop: occupancy is unchanged.
  - When empty, a push with rd_en high does not bypass; the new entry appears the next cycle.
- Pointers wrap modulo DEPTH. fifo_count ranges 0..DEPTH. Full means fifo_count==DEPTH.
- rd_source/rd_data hold their last value while empty; the bench must not check them unless rd_valid=1.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- clr_stats:
  - Clears src_cnt, drop_cnt and all sticky flags at the next edge.
  - If an event occurs in the same cycle, the clear wins: the event is not counted or flagged. FIFO storage is unaffected, so a good packet is still written.
  - FIFO contents and fifo_count are not affected.
- Packets on consecutive cycles are all accepted (full throughput). There is no backpressure to the switch.

Test Plan:
- Reset, then one packet with source=0001, target=0010, data=AA:
  - rd_valid=1 one cycle later, with rd_source=0001, rd_data=AA, fifo_count=1.
  - src_cnt[0]=1; pulse rd_en gives fifo_count=0 and rd_valid=0.
- Six back-to-back good packets (data 01..06, source=0100, rd_en=0, DEPTH=4):
  - fifo_count=4, drop_cnt=2, overflow=1, src_cnt[2]=4.
  - Popping returns 01,02,03,04 in order.
- Packet with target=0100, then a packet with source=0011:
  - misroute_err=1, bad_src_err=1, fifo_count=0, all src_cnt=0.
- FIFO full (4 entries), push data=55 with rd_en=1 in the same cycle:
  - No drop, fifo_count stays 4, and 55 is read fifth.
- clr_stats asserted in the same cycle as a good packet (source=1000, data=3C):
  - Afterwards src_cnt[3]=0 and flags are 0.
  - The packet is still readable with rd_data=3C.
- Assert rst_n=0 asynchronously between edges with 3 entries buffered:
  - rd_valid, fifo_count and all stats go to 0 immediately, before the next edge.

Source files
------------

// File: rtl/switch_port_rx.sv
// Egress receiver for one switch_4port output: validates packets,
// buffers good ones in a show-ahead FIFO and keeps delivery stats.
module switch_port_rx #(
    parameter logic [3:0] PORT_ID = 4'b0010,
    parameter int         DEPTH   = 4,
    parameter int         CNT_W   = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     pkt_valid,
    input  logic [3:0]               pkt_source,
    input  logic [3:0]               pkt_target,
    input  logic [7:0]               pkt_data,
    input  logic                     rd_en,
    output logic                     rd_valid,
    output logic [3:0]               rd_source,
    output logic [7:0]               rd_data,
    output logic [$clog2(DEPTH):0]   fifo_count,
    output logic [4*CNT_W-1:0]       src_cnt,
    output logic [CNT_W-1:0]         drop_cnt,
    output logic                     misroute_err,
    output logic                     bad_src_err,
    output logic                     overflow,
    input  logic                     clr_stats
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [11:0]      mem_q [DEPTH];
    logic [11:0]      mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0] src_cnt_q [4];
    logic [CNT_W-1:0] src_cnt_d [4];
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             mis_q, mis_d;
    logic             bad_q, bad_d;
    logic             ovf_q, ovf_d;

    logic src_onehot, is_mis, is_bad, is_good;
    logic full, pop, push, drop;

    // Classify the incoming packet; misroute beats bad source beats full
    always_comb begin
        src_onehot = (pkt_source != 4'b0) &&
                     ((pkt_source & (pkt_source - 4'd1)) == 4'b0);
        is_mis  = pkt_valid && (pkt_target != PORT_ID);
        is_bad  = pkt_valid && !is_mis &&
                  (!src_onehot || (pkt_source == PORT_ID));
        is_good = pkt_valid && !is_mis && !is_bad;
        full    = (cnt_q == FULL_CNT);
        pop     = rd_en && (cnt_q != '0);
        push    = is_good && (!full || pop);
        drop    = is_good && full && !pop;
    end

    // FIFO next state; a pop frees the slot a same-cycle push needs
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (push) begin
            mem_d[wr_ptr_q] = {pkt_source, pkt_data};
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pop && !push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Statistics next state; a clear overrides any same-cycle event
    always_comb begin
        src_cnt_d  = src_cnt_q;
        drop_cnt_d = drop_cnt_q;
        mis_d      = mis_q;
        bad_d      = bad_q;
        ovf_d      = ovf_q;
        if (clr_stats) begin
            for (int i = 0; i < 4; i++) begin
                src_cnt_d[i] = '0;
            end
            drop_cnt_d = '0;
            mis_d      = 1'b0;
            bad_d      = 1'b0;
            ovf_d      = 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (push && pkt_source[i] && (src_cnt_q[i] != CMAX)) begin
                    src_cnt_d[i] = src_cnt_q[i] + 1'b1;
                end
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_cnt_q != CMAX) begin
                    drop_cnt_d = drop_cnt_q + 1'b1;
                end
            end
            if (is_mis) begin
                mis_d = 1'b1;
            end
            if (is_bad) begin
                bad_d = 1'b1;
            end
        end
    end

    // FIFO storage and pointers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Counters and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                src_cnt_q[i] <= '0;
            end
            drop_cnt_q <= '0;
            mis_q      <= 1'b0;
            bad_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            src_cnt_q  <= src_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            mis_q      <= mis_d;
            bad_q      <= bad_d;
            ovf_q      <= ovf_d;
        end
    end

    // Output mapping; head entry is shown ahead of the pop
    always_comb begin
        src_cnt = '0;
        for (int i = 0; i < 4; i++) begin
            src_cnt[i*CNT_W +: CNT_W] = src_cnt_q[i];
        end
    end

    assign rd_valid                = (cnt_q != '0);
    assign {rd_source, rd_data}    = mem_q[rd_ptr_q];
    assign fifo_count              = cnt_q;
    assign drop_cnt                = drop_cnt_q;
    assign misroute_err            = mis_q;
    assign bad_src_err             = bad_q;
    assign overflow                = ovf_q;

endmodule

// File: tb/tb_switch_port_rx.sv
// Scoreboard bench for switch_port_rx: directed scenarios then random
// traffic against a queue-based reference model.
module tb_switch_port_rx;
    localparam logic [3:0] PID = 4'b0010;
    localparam int DEPTH = 4;
    localparam int CW    = 4;
    localparam int CMAX  = (1 << CW) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             pkt_valid;
    logic [3:0]       pkt_source;
    logic [3:0]       pkt_target;
    logic [7:0]       pkt_data;
    logic             rd_en;
    logic             rd_valid;
    logic [3:0]       rd_source;
    logic [7:0]       rd_data;
    logic [2:0]       fifo_count;
    logic [4*CW-1:0]  src_cnt;
    logic [CW-1:0]    drop_cnt;
    logic             misroute_err;
    logic             bad_src_err;
    logic             overflow;
    logic             clr_stats;

    switch_port_rx #(.PORT_ID(PID), .DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .pkt_valid(pkt_valid), .pkt_source(pkt_source),
        .pkt_target(pkt_target), .pkt_data(pkt_data),
        .rd_en(rd_en), .rd_valid(rd_valid),
        .rd_source(rd_source), .rd_data(rd_data),
        .fifo_count(fifo_count), .src_cnt(src_cnt),
        .drop_cnt(drop_cnt), .misroute_err(misroute_err),
        .bad_src_err(bad_src_err), .overflow(overflow),
        .clr_stats(clr_stats)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // reference model: stored entries, expected pops, stats
    logic [11:0] mq[$];
    logic [11:0] sb_q[$];
    int m_src[4];
    int m_drop;
    bit m_mis, m_bad, m_ovf;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic clear_stats_model();
        for (int i = 0; i < 4; i++) m_src[i] = 0;
        m_drop = 0;
        m_mis = 0;
        m_bad = 0;
        m_ovf = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".fifo_count"}, int'(fifo_count), mq.size());
        chk({tag, ".rd_valid"}, int'(rd_valid), int'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk({tag, ".head_src"}, int'(rd_source), int'(mq[0][11:8]));
            chk({tag, ".head_data"}, int'(rd_data), int'(mq[0][7:0]));
        end
        for (int i = 0; i < 4; i++)
            chk($sformatf("%s.src_cnt%0d", tag, i),
                int'(src_cnt[i*CW +: CW]), m_src[i]);
        chk({tag, ".drop_cnt"}, int'(drop_cnt), m_drop);
        chk({tag, ".misroute"}, int'(misroute_err), int'(m_mis));
        chk({tag, ".bad_src"}, int'(bad_src_err), int'(m_bad));
        chk({tag, ".overflow"}, int'(overflow), int'(m_ovf));
    endtask

    // one clock of stimulus; model decides the outcome from the rules
    task automatic step(input string tag, input bit v, input logic [3:0] s,
                        input logic [3:0] t, input logic [7:0] d,
                        input bit rd, input bit clr);
        bit mis, bad, good, pop, full, push, drop;
        pkt_valid  = v;
        pkt_source = s;
        pkt_target = t;
        pkt_data   = d;
        rd_en      = rd;
        clr_stats  = clr;
        mis  = v && (t != PID);
        bad  = v && !mis && (($countones(s) != 1) || (s == PID));
        good = v && !mis && !bad;
        pop  = rd && (mq.size() > 0);
        full = (mq.size() == DEPTH);
        push = good && (!full || pop);
        drop = good && full && !pop;
        if (push) sb_q.push_back({s, d});
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back({s, d});
        if (clr) clear_stats_model();
        else begin
            for (int i = 0; i < 4; i++)
                if (push && s[i] && m_src[i] < CMAX) m_src[i]++;
            if (drop) begin
                m_ovf = 1;
                if (m_drop < CMAX) m_drop++;
            end
            if (mis) m_mis = 1;
            if (bad) m_bad = 1;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input bit rd);
        step(tag, 0, 4'b0, 4'b0, 8'h00, rd, 0);
    endtask

    // monitor: every pop the DUT performs must match the scoreboard head
    always @(negedge clk) begin
        if (rst_n && rd_valid && rd_en) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL pop_data: got %0h with nothing expected",
                         {rd_source, rd_data});
            end else begin
                logic [11:0] e;
                e = sb_q.pop_front();
                chk("pop_src", int'(rd_source), int'(e[11:8]));
                chk("pop_data", int'(rd_data), int'(e[7:0]));
            end
        end
    end

    function automatic logic [3:0] rnd_src();
        logic [3:0] r;
        if ($urandom_range(3) != 0) r = 4'b1 << $urandom_range(3);
        else r = 4'($urandom);
        return r;
    endfunction

    initial begin
        rst_n = 1'b0;
        pkt_valid = 0; pkt_source = 0; pkt_target = 0; pkt_data = 0;
        rd_en = 0; clr_stats = 0;
        clear_stats_model();
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        chk("reset.rd_source", int'(rd_source), 0);
        chk("reset.rd_data", int'(rd_data), 0);
        rst_n = 1'b1;

        // single packet, visible next cycle, then popped
        step("single", 1, 4'b0001, PID, 8'hAA, 0, 0);
        idle("single_pop", 1);

        // overfill: 4 stored, 2 dropped, FIFO order on drain
        for (int k = 1; k <= 6; k++)
            step("fill6", 1, 4'b0100, PID, 8'(k), 0, 0);
        repeat (4) idle("drain6", 1);

        // start from clean stats, then misroute and bad source
        idle("clr", 0);
        step("clr", 0, 4'b0, 4'b0, 8'h00, 0, 1);
        step("misroute", 1, 4'b0001, 4'b0100, 8'h11, 0, 0);
        step("badsrc", 1, 4'b0011, PID, 8'h22, 0, 0);
        step("selfsrc", 1, PID, PID, 8'h23, 0, 0);

        // full FIFO with push and pop together: no drop
        for (int k = 0; k < 4; k++)
            step("fill4", 1, 4'b0001, PID, 8'h10 + 8'(k), 0, 0);
        step("full_pushpop", 1, 4'b1000, PID, 8'h55, 1, 0);
        repeat (4) idle("drain55", 1);

        // clear in same cycle as a good packet
        step("clr_push", 1, 4'b1000, PID, 8'h3C, 0, 1);
        idle("clr_pop", 1);

        // async reset with three entries buffered
        for (int k = 0; k < 3; k++)
            step("pre_rst", 1, 4'b0100, PID, 8'hC0 + 8'(k), 0, 0);
        step("pre_rst_drop", 1, 4'b0001, 4'b1000, 8'h00, 0, 0);
        pkt_valid = 0; rd_en = 0; clr_stats = 0;
        #2;
        rst_n = 1'b0;
        #1;
        mq.delete();
        sb_q.delete();
        clear_stats_model();
        check_all("async_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // random traffic: low pop rate first to hit full and saturation
        for (int n = 0; n < 300; n++)
            step("rnd_a", $urandom_range(9) < 8, rnd_src(),
                 ($urandom_range(9) < 9) ? PID : 4'($urandom),
                 8'($urandom), $urandom_range(3) == 0, 0);
        for (int n = 0; n < 300; n++)
            step("rnd_b", $urandom_range(9) < 6, rnd_src(),
                 ($urandom_range(9) < 8) ? PID : 4'($urandom),
                 8'($urandom), $urandom_range(1) == 1,
                 $urandom_range(19) == 0);
        repeat (DEPTH + 1) idle("final_drain", 1);
        chk("sb_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
